// File: rtl/sobel_mag.sv
// -----------------------------------------------------------------------------
// sobel_mag
// Consumes 4x4 Sobel gradient tiles. On a sobel_done pulse the gx/gy tiles are
// captured; the magnitude |gx|+|gy| (saturated to DW bits) is then produced one
// pixel per clock in row-major order. Each magnitude is thresholded into an
// edge bit. The finished tile is offered downstream on a valid/ready handshake.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   sobel_done  one-cycle pulse, data_x/data_y valid in that cycle
//   data_x      4x4 horizontal gradients, two's complement
//   data_y      4x4 vertical gradients, two's complement
//   mag_valid   result tile valid, held until accepted
//   mag_ready   downstream accepts when mag_valid && mag_ready
//   mag_map     4x4 unsigned saturated magnitudes
//   edge_map    bit (4*r+c) is the edge flag of pixel [r][c]
//   edge_count  number of set bits in edge_map (0..16)
//   overrun     sticky flag, a sobel_done pulse was dropped
// -----------------------------------------------------------------------------
module sobel_mag #(
    parameter int              DW     = 9,
    parameter logic [DW-1:0]   THRESH = 9'd64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sobel_done,
    input  logic [3:0][3:0][DW-1:0]   data_x,
    input  logic [3:0][3:0][DW-1:0]   data_y,
    output logic                      mag_valid,
    input  logic                      mag_ready,
    output logic [3:0][3:0][DW-1:0]   mag_map,
    output logic [15:0]               edge_map,
    output logic [4:0]                edge_count,
    output logic                      overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state, state_nxt;
    logic [3:0]                idx;
    logic [3:0][3:0][DW-1:0]   gx_reg;
    logic [3:0][3:0][DW-1:0]   gy_reg;

    // Control decode
    logic capture;      // take a new tile this cycle
    logic accept;       // downstream takes the finished tile
    logic overrun_set;  // a pulse arrived that cannot be honoured
    logic calc_en;      // process pixel idx this cycle
    logic last_pix;

    // Per-pixel arithmetic
    logic [DW-1:0]   px_x, px_y;
    logic [DW:0]     abs_x, abs_y;
    logic [DW:0]     sum;
    logic [DW-1:0]   mag;
    logic            is_edge;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top of each always_comb keeps every
    // path assigned, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (sobel_done) state_nxt = CALC;
            CALC: if (last_pix)   state_nxt = DONE;
            DONE: if (mag_ready)  state_nxt = sobel_done ? CALC : IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / control decode
    // -------------------------------------------------------------------------
    always_comb begin
        capture     = 1'b0;
        accept      = 1'b0;
        overrun_set = 1'b0;
        calc_en     = 1'b0;
        last_pix    = (idx == 4'd15);
        unique case (state)
            IDLE: capture = sobel_done;
            CALC: begin
                calc_en     = 1'b1;
                overrun_set = sobel_done;
            end
            DONE: begin
                accept      = mag_ready;
                capture     = mag_ready && sobel_done;
                overrun_set = !mag_ready && sobel_done;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Magnitude of the current pixel. abs() is taken in DW+1 bits so the most
    // negative input maps to 2^(DW-1) exactly; the sum's top bit is set only
    // when it exceeds 2^DW-1, which is where saturation kicks in.
    // -------------------------------------------------------------------------
    always_comb begin
        px_x  = gx_reg[idx[3:2]][idx[1:0]];
        px_y  = gy_reg[idx[3:2]][idx[1:0]];
        abs_x = px_x[DW-1] ? ({1'b0, ~px_x} + 1'b1) : {1'b0, px_x};
        abs_y = px_y[DW-1] ? ({1'b0, ~px_y} + 1'b1) : {1'b0, px_y};
        sum   = abs_x + abs_y;
        mag   = sum[DW] ? {DW{1'b1}} : sum[DW-1:0];
        is_edge = (mag >= THRESH);
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    // NOTE: the capture tiles are cleared on reset as well so a reset leaves no
    // stale gradient data behind; they are flops, not a RAM, so this is cheap.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            gx_reg     <= '0;
            gy_reg     <= '0;
            mag_map    <= '0;
            edge_map   <= '0;
            edge_count <= '0;
            mag_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (overrun_set) overrun <= 1'b1;

            if (capture) begin
                gx_reg     <= data_x;
                gy_reg     <= data_y;
                mag_map    <= '0;
                edge_map   <= '0;
                edge_count <= '0;
                idx        <= '0;
                mag_valid  <= 1'b0;
            end else if (calc_en) begin
                mag_map[idx[3:2]][idx[1:0]] <= mag;
                edge_map[idx]               <= is_edge;
                if (is_edge) edge_count <= edge_count + 5'd1;
                if (last_pix) mag_valid <= 1'b1;
                else          idx       <= idx + 4'd1;
            end else if (accept) begin
                mag_valid <= 1'b0;
            end
        end
    end

endmodule
